// File: rtl/floor_request_queue_if.sv
// Bundles the call-button, floor-position and queue-status signals between the
// elevator controller side (master) and the request queue (slave).
interface floor_request_queue_if #(
    parameter int unsigned NUM_FLOORS = 10
);
    logic [NUM_FLOORS-1:0] call_btn;
    logic [3:0]            current_floor;
    logic [3:0]            requested_floor;
    logic [NUM_FLOORS-1:0] pending;
    logic                  door_open;
    logic                  busy;

    modport master (
        output call_btn,
        output current_floor,
        input  requested_floor,
        input  pending,
        input  door_open,
        input  busy
    );

    modport slave (
        input  call_btn,
        input  current_floor,
        output requested_floor,
        output pending,
        output door_open,
        output busy
    );
endinterface

// File: rtl/floor_request_queue.sv
// Elevator floor request queue: latches call-button edges, picks the next target
// floor with directional (collective) scheduling and times the door dwell.
module floor_request_queue #(
    parameter int unsigned NUM_FLOORS  = 10,
    parameter int unsigned DWELL_COUNT = 32'd20000000
) (
    input  logic                   clk,
    input  logic                   reset,
    floor_request_queue_if.slave   bus
);

    typedef enum logic [1:0] {StIdle, StServe, StDwell} state_e;

    state_e                r_state, w_state_next;
    logic [3:0]            r_req_floor, w_req_next;
    logic                  r_dir_up, w_dir_next;
    logic                  r_door, w_door_next;
    logic [31:0]           r_dwell_cnt, w_cnt_next;
    logic [NUM_FLOORS-1:0] r_pending;
    logic [NUM_FLOORS-1:0] r_btn_q;
    logic                  r_armed;

    logic [NUM_FLOORS-1:0] w_new_req;
    logic [NUM_FLOORS-1:0] w_clear_mask;
    logic                  w_clr_en;
    logic [3:0]            w_clr_floor;
    logic                  w_cur_valid;
    logic                  w_pend_at_cur;
    logic                  w_above_found, w_below_found;
    logic [3:0]            w_above_idx, w_below_idx;

    // Edge detection is suppressed until one cycle after reset release so a
    // button held across reset does not look like a fresh press.
    assign w_new_req   = r_armed ? (bus.call_btn & ~r_btn_q) : '0;
    assign w_cur_valid = 32'(bus.current_floor) < NUM_FLOORS;

    always_comb begin
        w_pend_at_cur = 1'b0;
        w_above_found = 1'b0;
        w_above_idx   = '0;
        w_below_found = 1'b0;
        w_below_idx   = '0;
        for (int i = 0; i < int'(NUM_FLOORS); i++) begin
            if (i == int'(bus.current_floor)) w_pend_at_cur = r_pending[i];
        end
        // Descending scan leaves the lowest pending floor above current.
        for (int i = int'(NUM_FLOORS) - 1; i >= 0; i--) begin
            if (r_pending[i] && (i > int'(bus.current_floor))) begin
                w_above_found = 1'b1;
                w_above_idx   = 4'(i);
            end
        end
        for (int i = 0; i < int'(NUM_FLOORS); i++) begin
            if (r_pending[i] && (i < int'(bus.current_floor))) begin
                w_below_found = 1'b1;
                w_below_idx   = 4'(i);
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_req_next   = r_req_floor;
        w_dir_next   = r_dir_up;
        w_door_next  = r_door;
        w_cnt_next   = r_dwell_cnt;
        w_clr_en     = 1'b0;
        w_clr_floor  = bus.current_floor;
        case (r_state)
            StIdle: begin
                if (r_pending != '0) begin
                    if (w_cur_valid && w_pend_at_cur) begin
                        w_clr_en     = 1'b1;
                        w_cnt_next   = '0;
                        w_door_next  = 1'b1;
                        w_state_next = StDwell;
                    end else if (w_above_found && (r_dir_up || !w_below_found)) begin
                        w_req_next   = w_above_idx;
                        w_dir_next   = 1'b1;
                        w_state_next = StServe;
                    end else begin
                        w_req_next   = w_below_idx;
                        w_dir_next   = 1'b0;
                        w_state_next = StServe;
                    end
                end
            end
            StServe: begin
                // An out-of-range floor report freezes the queue until it recovers.
                if (w_cur_valid) begin
                    if (bus.current_floor == r_req_floor) begin
                        w_clr_en     = 1'b1;
                        w_clr_floor  = r_req_floor;
                        w_cnt_next   = '0;
                        w_door_next  = 1'b1;
                        w_state_next = StDwell;
                    end else if (r_dir_up && w_above_found && (w_above_idx < r_req_floor)) begin
                        w_req_next = w_above_idx;
                    end else if (!r_dir_up && w_below_found && (w_below_idx > r_req_floor)) begin
                        w_req_next = w_below_idx;
                    end
                end
            end
            StDwell: begin
                w_cnt_next = r_dwell_cnt + 32'd1;
                if (r_dwell_cnt == 32'(DWELL_COUNT - 1)) begin
                    w_door_next  = 1'b0;
                    w_cnt_next   = '0;
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_comb begin
        w_clear_mask = '0;
        for (int i = 0; i < int'(NUM_FLOORS); i++) begin
            if (w_clr_en && (i == int'(w_clr_floor))) w_clear_mask[i] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= StIdle;
            r_req_floor <= '0;
            r_dir_up    <= 1'b1;
            r_door      <= 1'b0;
            r_dwell_cnt <= '0;
            r_pending   <= '0;
            r_btn_q     <= '0;
            r_armed     <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_req_floor <= w_req_next;
            r_dir_up    <= w_dir_next;
            r_door      <= w_door_next;
            r_dwell_cnt <= w_cnt_next;
            // Clear wins over a same-cycle press on the floor being served.
            r_pending   <= (r_pending | w_new_req) & ~w_clear_mask;
            r_btn_q     <= bus.call_btn;
            r_armed     <= 1'b1;
        end
    end

    assign bus.requested_floor = r_req_floor;
    assign bus.pending         = r_pending;
    assign bus.door_open       = r_door;
    assign bus.busy            = (r_state != StIdle);

endmodule

// File: tb/tb_floor_request_queue.sv
// Directed self-checking bench for floor_request_queue with a 4-cycle dwell.
module tb_floor_request_queue;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    floor_request_queue_if #(.NUM_FLOORS(10)) bus ();

    floor_request_queue #(
        .NUM_FLOORS (10),
        .DWELL_COUNT(4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        bus.call_btn = '0;
        #2;
        @(posedge clk);
        #1;
        reset = 1'b1;
        tick();
    endtask

    task automatic press(input logic [9:0] mask);
        bus.call_btn = mask;
        tick();
        bus.call_btn = '0;
    endtask

    task automatic test_reset();
        bus.call_btn = '0;
        bus.current_floor = 4'd0;
        reset = 1'b0;
        #3;
        n_tests++;
        if (bus.requested_floor !== 4'd0) begin
            n_fail++; $display("FAIL rst_req got=%0d want=0", bus.requested_floor);
        end
        n_tests++;
        if (bus.pending !== 10'h000) begin
            n_fail++; $display("FAIL rst_pending got=%h want=000", bus.pending);
        end
        n_tests++;
        if (bus.door_open !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL rst_door_busy got=%b%b want=00", bus.door_open, bus.busy);
        end
    endtask

    task automatic test_serve_basic();
        int cnt;
        bus.current_floor = 4'd0;
        do_reset();
        press(10'h008);
        n_tests++;
        if (bus.pending !== 10'h008 || bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL basic_latch got=%h/%b want=008/0", bus.pending, bus.busy);
        end
        tick();
        n_tests++;
        if (bus.requested_floor !== 4'd3 || bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_target got=%0d/%b want=3/1", bus.requested_floor, bus.busy);
        end
        bus.current_floor = 4'd3;
        tick();
        n_tests++;
        if (bus.pending !== 10'h000 || bus.door_open !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_arrive got=%h/%b want=000/1", bus.pending, bus.door_open);
        end
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            if (bus.door_open === 1'b1) cnt++;
            tick();
        end
        n_tests++;
        if (cnt != 4 || bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL basic_dwell got=%0d/%b want=4/0", cnt, bus.busy);
        end
    endtask

    task automatic test_direction();
        bus.current_floor = 4'd5;
        do_reset();
        press(10'h084);
        n_tests++;
        if (bus.pending !== 10'h084) begin
            n_fail++; $display("FAIL dir_latch got=%h want=084", bus.pending);
        end
        tick();
        n_tests++;
        if (bus.requested_floor !== 4'd7 || dut.r_dir_up !== 1'b1) begin
            n_fail++;
            $display("FAIL dir_up_pick got=%0d/%b want=7/1", bus.requested_floor, dut.r_dir_up);
        end
        bus.current_floor = 4'd7;
        tick();
        n_tests++;
        if (bus.pending !== 10'h004 || bus.door_open !== 1'b1) begin
            n_fail++;
            $display("FAIL dir_serve7 got=%h/%b want=004/1", bus.pending, bus.door_open);
        end
        repeat (4) tick();
        n_tests++;
        if (bus.door_open !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL dir_idle got=%b/%b want=0/0", bus.door_open, bus.busy);
        end
        tick();
        n_tests++;
        if (bus.requested_floor !== 4'd2 || dut.r_dir_up !== 1'b0 || bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL dir_down_pick got=%0d/%b/%b want=2/0/1",
                     bus.requested_floor, dut.r_dir_up, bus.busy);
        end
    endtask

    task automatic test_pickup();
        bus.current_floor = 4'd2;
        do_reset();
        press(10'h100);
        tick();
        n_tests++;
        if (bus.requested_floor !== 4'd8) begin
            n_fail++; $display("FAIL pick_target got=%0d want=8", bus.requested_floor);
        end
        bus.current_floor = 4'd3;
        press(10'h020);
        tick();
        n_tests++;
        if (bus.requested_floor !== 4'd5) begin
            n_fail++; $display("FAIL pick_retarget got=%0d want=5", bus.requested_floor);
        end
        press(10'h002);
        tick();
        n_tests++;
        if (bus.requested_floor !== 4'd5 || bus.pending !== 10'h122) begin
            n_fail++;
            $display("FAIL pick_behind got=%0d/%h want=5/122", bus.requested_floor, bus.pending);
        end
    endtask

    task automatic test_direct_dwell();
        int cnt;
        bus.current_floor = 4'd4;
        do_reset();
        press(10'h010);
        tick();
        n_tests++;
        if (bus.busy !== 1'b1 || bus.door_open !== 1'b1 || bus.pending !== 10'h000 ||
            bus.requested_floor !== 4'd0) begin
            n_fail++;
            $display("FAIL direct_enter got=%b/%b/%h/%0d want=1/1/000/0",
                     bus.busy, bus.door_open, bus.pending, bus.requested_floor);
        end
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            if (bus.door_open === 1'b1) cnt++;
            tick();
        end
        n_tests++;
        if (cnt != 4 || bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL direct_dwell got=%0d/%b want=4/0", cnt, bus.busy);
        end
    endtask

    task automatic test_button_hold();
        bus.current_floor = 4'd0;
        do_reset();
        bus.call_btn = 10'h040;
        repeat (10) tick();
        n_tests++;
        if (bus.pending !== 10'h040 || bus.requested_floor !== 4'd6) begin
            n_fail++;
            $display("FAIL hold_single got=%h/%0d want=040/6", bus.pending, bus.requested_floor);
        end
        bus.call_btn = '0;
        tick();
        bus.current_floor = 4'd6;
        bus.call_btn = 10'h040;
        tick();
        n_tests++;
        if (bus.pending !== 10'h000 || bus.door_open !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_clear_wins got=%h/%b want=000/1", bus.pending, bus.door_open);
        end
        bus.call_btn = '0;
        tick();
        bus.call_btn = 10'h040;
        tick();
        bus.call_btn = '0;
        n_tests++;
        if (bus.pending !== 10'h040) begin
            n_fail++; $display("FAIL hold_repress got=%h want=040", bus.pending);
        end
        repeat (2) tick();
        n_tests++;
        if (bus.door_open !== 1'b0 || bus.busy !== 1'b0 || bus.pending !== 10'h040) begin
            n_fail++;
            $display("FAIL hold_idle got=%b/%b/%h want=0/0/040",
                     bus.door_open, bus.busy, bus.pending);
        end
        tick();
        n_tests++;
        if (bus.door_open !== 1'b1 || bus.pending !== 10'h000) begin
            n_fail++;
            $display("FAIL hold_reserve got=%b/%h want=1/000", bus.door_open, bus.pending);
        end
    endtask

    task automatic test_reset_midop();
        bus.current_floor = 4'd3;
        do_reset();
        press(10'h008);
        press(10'h0A0);
        n_tests++;
        if (bus.pending !== 10'h0A0 || bus.door_open !== 1'b1 || bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_setup got=%h/%b/%b want=0a0/1/1",
                     bus.pending, bus.door_open, bus.busy);
        end
        bus.call_btn = 10'h0A0;
        #2;
        reset = 1'b0;
        #1;
        n_tests++;
        if (bus.pending !== 10'h000 || bus.door_open !== 1'b0 || bus.busy !== 1'b0 ||
            bus.requested_floor !== 4'd0 || dut.r_dir_up !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_async got=%h/%b/%b/%0d/%b want=000/0/0/0/1", bus.pending,
                     bus.door_open, bus.busy, bus.requested_floor, dut.r_dir_up);
        end
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (3) tick();
        n_tests++;
        if (bus.pending !== 10'h000 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_held_btn got=%h/%b want=000/0", bus.pending, bus.busy);
        end
        bus.call_btn = '0;
        tick();
        press(10'h0A0);
        n_tests++;
        if (bus.pending !== 10'h0A0) begin
            n_fail++; $display("FAIL mid_new_press got=%h want=0a0", bus.pending);
        end
    endtask

    initial begin
        bus.call_btn = '0;
        bus.current_floor = 4'd0;
        test_reset();
        test_serve_basic();
        test_direction();
        test_pickup();
        test_direct_dwell();
        test_button_hold();
        test_reset_midop();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
